fft8_reorder_sched: RTL and testbench

//   Streaming input scheduler for the 8-point radix-2 FFT/IFFT datapath. It accepts complex samples
//   one per cycle in natural order and stores them in a ping-pong (2-bank) buffer. It replays each

---
 rtl/fft8_reorder_sched.sv | 97 +++++++++
 tb/tb_fft8_reorder_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_reorder_sched.sv
// Ping-pong frame buffer: natural-order complex samples in, bit-reversed frames out to the FFT core.
// Latency: slot 0 is valid the cycle after the N-th sample of a frame is accepted.
// Backpressure: in_ready falls only when both banks hold undrained frames; outputs hold while out_ready=0.
module fft8_reorder_sched #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_last,
    output logic [7:0]        frame_count
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [2*DATA_W-1:0] mem [2][N];
    logic                wr_bank;
    logic                rd_bank;
    logic [LOG2N-1:0]    wr_cnt;
    logic [LOG2N-1:0]    rd_cnt;
    logic [1:0]          full;
    logic                wr_en;
    logic                rd_en;
    logic [2*DATA_W-1:0] rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    // Data is gated with out_valid so idle/reset outputs read as zero rather than stale memory.
    assign rd_word   = mem[rd_bank][bitrev(rd_cnt)];
    assign out_real  = out_valid ? rd_word[2*DATA_W-1:DATA_W] : '0;
    assign out_imag  = out_valid ? rd_word[DATA_W-1:0] : '0;
    assign out_index = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == LAST);

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_bank][wr_cnt] <= {in_real, in_imag};
        end
    end

    // A write can only complete into an empty bank and a read only drain a full one,
    // so same-cycle completions always touch different full[] bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            full        <= 2'b00;
            frame_count <= 8'd0;
        end else if (flush) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= 2'b00;
        end else begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    frame_count   <= frame_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft8_reorder_sched.sv
// Bench for fft8_reorder_sched: queue-based reference model feeding a scoreboard monitor.
module tb_fft8_reorder_sched;
    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic [2:0]  out_index;
    logic        out_last;
    logic [7:0]  frame_count;

    fft8_reorder_sched #(.DATA_W(16), .LOG2N(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        expq[$];
    logic [15:0] part_re[$];
    logic [15:0] part_im[$];
    int          model_frames = 0;
    int          fires = 0;
    int          accepted = 0;
    logic [15:0] cur_re = '0;
    logic [15:0] cur_im = '0;
    bit          rand_data = 1'b0;
    logic        s_in_ready, s_out_valid, s_out_last;
    logic [2:0]  s_out_index;
    logic [15:0] s_out_real, s_out_imag;
    logic [7:0]  s_fc;
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Reference: collect a natural-order frame, then emit slot k carrying sample bitrev(k).
    task automatic model_accept(input logic [15:0] re, input logic [15:0] im);
        exp_t e;
        int   j;
        part_re.push_back(re);
        part_im.push_back(im);
        if (part_re.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                j = 0;
                for (int b = 0; b < 3; b++) begin
                    if (((k >> b) & 1) != 0) j += 1 << (2 - b);
                end
                e.re   = part_re[j];
                e.im   = part_im[j];
                e.idx  = 3'(k);
                e.last = (k == 7);
                expq.push_back(e);
            end
            part_re.delete();
            part_im.delete();
        end
    endtask

    task automatic step(input bit v, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = v;
        in_real   = cur_re;
        in_imag   = cur_im;
        out_ready = ordy;
        flush     = fl;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_last  = out_last;
        s_out_index = out_index;
        s_out_real  = out_real;
        s_out_imag  = out_imag;
        s_fc        = frame_count;
        if (fl) begin
            part_re.delete();
            part_im.delete();
            expq.delete();
        end else if (v && in_ready && rst_n) begin
            model_accept(cur_re, cur_im);
            accepted++;
            if (rand_data) begin
                cur_re = 16'($urandom);
                cur_im = 16'($urandom);
            end else begin
                cur_re = cur_re + 16'd1;
                cur_im = cur_im + 16'd1;
            end
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (expq.size() != 0 && k < bound) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        step(1'b0, 1'b1, 1'b0);
        chk("drain_done", 64'(expq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && !flush && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_unexpected: got slot %0d, expected no output", out_index);
            end else begin
                mon_e = expq.pop_front();
                chk("out_sample", 64'({out_real, out_imag, out_index, out_last}), 64'(mon_e));
                fires++;
                if (mon_e.last) model_frames++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, f0, drops, vcnt;
        logic [7:0] fc0;
        logic [34:0] held;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'({out_real, out_imag}), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame, latency and first slots
        cur_re = 16'd0;
        cur_im = 16'd100;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        chk("lat_not_early", 64'(s_out_valid), 64'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_valid", 64'(s_out_valid), 64'd1);
        chk("slot0", 64'({s_out_index, s_out_real, s_out_imag}), 64'({3'd0, 16'd0, 16'd100}));
        step(1'b0, 1'b1, 1'b0);
        chk("slot1", 64'({s_out_index, s_out_real, s_out_imag}), 64'({3'd1, 16'd4, 16'd104}));
        drain(40);
        chk("fc_one_frame", 64'(s_fc), 64'd1);

        // Three back-to-back frames at full rate
        f0 = fires;
        drops = 0;
        vcnt = 0;
        cur_re = 16'h1000;
        cur_im = 16'h2000;
        for (int i = 0; i < 32; i++) begin
            step(i < 24, 1'b1, 1'b0);
            if (i < 24 && !s_in_ready) drops++;
            if (i >= 8 && s_out_valid) vcnt++;
        end
        step(1'b0, 1'b1, 1'b0);
        chk("stream_in_ready_drops", 64'(drops), 64'd0);
        chk("stream_out_consecutive", 64'(vcnt), 64'd24);
        chk("stream_fires", 64'(fires - f0), 64'd24);
        chk("fc_after_stream", 64'(s_fc), 64'd4);

        // Full backpressure: two banks fill, then in_ready drops and slot 0 holds
        acc0 = accepted;
        cur_re = 16'd200;
        cur_im = 16'd300;
        held = '0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 16) held = {s_out_index, s_out_real, s_out_imag};
        end
        chk("bp_accepted", 64'(accepted - acc0), 64'd16);
        chk("bp_in_ready", 64'(s_in_ready), 64'd0);
        chk("bp_out_valid", 64'(s_out_valid), 64'd1);
        chk("bp_hold", 64'({s_out_index, s_out_real, s_out_imag}), 64'(held));
        chk("bp_slot0", 64'(s_out_index), 64'd0);
        for (int k = 0; k < 200 && (accepted - acc0) < 24; k++) step(1'b1, 1'b1, 1'b0);
        drain(60);
        chk("fc_after_bp", 64'(s_fc), 64'(model_frames % 256));

        // Flush with one frame full and three samples of the next
        cur_re = 16'd400;
        cur_im = 16'd450;
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);
        fc0 = s_fc;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("flush_out_valid", 64'(s_out_valid), 64'd0);
        chk("flush_in_ready", 64'(s_in_ready), 64'd1);
        chk("flush_fc_kept", 64'(s_fc), 64'(fc0));
        cur_re = 16'd10;
        cur_im = 16'd110;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("flush_slot0", 64'({s_out_index, s_out_real}), 64'({3'd0, 16'd10}));
        step(1'b0, 1'b1, 1'b0);
        chk("flush_slot1", 64'({s_out_index, s_out_real}), 64'({3'd1, 16'd14}));
        drain(40);

        // Asynchronous reset while rd_cnt = 3
        cur_re = 16'd500;
        cur_im = 16'd600;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("mid_rd_cnt", 64'(s_out_index), 64'd3);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_frame_count", 64'(frame_count), 64'd0);
        part_re.delete();
        part_im.delete();
        expq.delete();
        model_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_data = 1'b1;
        cur_re = 16'($urandom);
        cur_im = 16'($urandom);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        drain(40);
        chk("fc_after_arst", 64'(s_fc), 64'd1);

        // 255 more frames with random stalls: frame_count wraps to 0
        acc0 = accepted;
        for (int k = 0; k < 30000 && (accepted - acc0) < 255 * 8; k++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), 1'b0);
        end
        chk("rand_accepted", 64'(accepted - acc0), 64'(255 * 8));
        drain(200);
        chk("rand_fc_model", 64'(s_fc), 64'(model_frames % 256));
        chk("rand_fc_wrap", 64'(s_fc), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
